// File: rtl/alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_issue_stage                                               |
// | Purpose  : Command FIFO feeding a combinational ALU, with a registered,  |
// |            handshaked result stage. Optional macro: ALU_OPCHECK_EN        |
// |            (drop commands with opcode >= 3'b110 and pulse err_op).       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module alu_issue_stage #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_a,
    input  logic [W-1:0]               in_b,
    input  logic [2:0]                 in_op,
    output logic [W-1:0]               alu_a,
    output logic [W-1:0]               alu_b,
    output logic [2:0]                 alu_op,
    input  logic [W-1:0]               alu_res,
    input  logic                       alu_carry,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_res,
    output logic                       out_carry,
    output logic [2:0]                 out_op,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err_op
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] c_depth     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one  = ADDR_W'(1);

    // Output register occupancy
    localparam logic [0:0] c_out_empty = 1'b0;
    localparam logic [0:0] c_out_full  = 1'b1;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [0:0]        r_out_state;
    logic [0:0]        w_out_state_nxt;
    logic [W-1:0]      r_out_res;
    logic              r_out_carry;
    logic [2:0]        r_out_op;

    logic              w_push;
    logic              w_write;
    logic              w_pop;
    logic              w_empty;
    logic              w_op_illegal;
    logic              w_out_valid;

    logic [W-1:0]      w_ent_a  [DEPTH];
    logic [W-1:0]      w_ent_b  [DEPTH];
    logic [2:0]        w_ent_op [DEPTH];

    assign w_empty     = (r_count == '0);
    assign in_ready    = (r_count < c_depth);
    assign w_push      = in_valid & in_ready;
    assign w_write     = w_push & ~w_op_illegal;
    assign w_out_valid = (r_out_state == c_out_full);
    assign w_pop       = ~w_empty & (~w_out_valid | out_ready);

    // One register set per FIFO slot, written only when the write pointer selects it
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [W-1:0] r_a;
            logic [W-1:0] r_b;
            logic [2:0]   r_op;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a  <= '0;
                    r_b  <= '0;
                    r_op <= '0;
                end else if (w_write && (r_wr_ptr == ADDR_W'(gi))) begin
                    r_a  <= in_a;
                    r_b  <= in_b;
                    r_op <= in_op;
                end
            end

            assign w_ent_a[gi]  = r_a;
            assign w_ent_b[gi]  = r_b;
            assign w_ent_op[gi] = r_op;
        end
    endgenerate

    assign alu_a  = w_empty ? '0   : w_ent_a[r_rd_ptr];
    assign alu_b  = w_empty ? '0   : w_ent_b[r_rd_ptr];
    assign alu_op = w_empty ? 3'b0 : w_ent_op[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_write && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_write && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    always_comb begin
        w_out_state_nxt = r_out_state;
        case (r_out_state)
            c_out_empty: begin
                if (w_pop) begin
                    w_out_state_nxt = c_out_full;
                end
            end
            c_out_full: begin
                if (w_pop) begin
                    w_out_state_nxt = c_out_full;
                end else if (out_ready) begin
                    w_out_state_nxt = c_out_empty;
                end
            end
            default: w_out_state_nxt = c_out_empty;
        endcase
    end

    // Result fields only move on a pop, so they hold through a drain and a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_state <= c_out_empty;
            r_out_res   <= '0;
            r_out_carry <= 1'b0;
            r_out_op    <= 3'b0;
        end else begin
            r_out_state <= w_out_state_nxt;
            if (w_pop) begin
                r_out_res   <= alu_res;
                r_out_carry <= alu_carry;
                r_out_op    <= alu_op;
            end
        end
    end

`ifdef ALU_OPCHECK_EN
    logic r_err_op;

    assign w_op_illegal = (in_op >= 3'b110);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_op <= 1'b0;
        end else begin
            r_err_op <= w_push & w_op_illegal;
        end
    end

    assign err_op = r_err_op;
`else
    assign w_op_illegal = 1'b0;
    assign err_op       = 1'b0;
`endif

    assign out_valid  = w_out_valid;
    assign out_res    = r_out_res;
    assign out_carry  = r_out_carry;
    assign out_op     = r_out_op;
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_issue_stage                                            |
// | Purpose  : Directed and random checks of alu_issue_stage against a       |
// |            queue-based reference model; honours ALU_OPCHECK_EN.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_issue_stage;

    localparam int W     = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
    } cmd_t;

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [W-1:0]             in_a;
    logic [W-1:0]             in_b;
    logic [2:0]               in_op;
    logic [W-1:0]             alu_a;
    logic [W-1:0]             alu_b;
    logic [2:0]               alu_op;
    logic [W-1:0]             alu_res;
    logic                     alu_carry;
    logic                     out_valid;
    logic                     out_ready;
    logic [W-1:0]             out_res;
    logic                     out_carry;
    logic [2:0]               out_op;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     err_op;

    int n_vectors;
    int n_miscompares;

    cmd_t     m_q[$];
    bit       m_valid;
    int       m_res;
    bit       m_carry;
    int       m_op;
    bit       m_err;

    cmd_t     sc_cmd[6];

    alu_issue_stage #(.W(W), .DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_res    (alu_res),
        .alu_carry  (alu_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_carry  (out_carry),
        .out_op     (out_op),
        .fifo_count (fifo_count),
        .err_op     (err_op)
    );

    // Behavioural adder standing in for simple_alu
    assign {alu_carry, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sum_of(input cmd_t c);
        return int'(c.a) + int'(c.b);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_valid = 0;
        m_res   = 0;
        m_carry = 0;
        m_op    = 0;
        m_err   = 0;
    endtask

    // Advance the reference by one clock edge given the inputs in force before it
    task automatic model_step(input bit v, input cmd_t c, input bit ordy);
        bit   ready, push, pop, illegal;
        cmd_t h;
        ready   = (m_q.size() < DEPTH);
        push    = v && ready;
        illegal = 0;
`ifdef ALU_OPCHECK_EN
        illegal = (c.op >= 3'd6);
`endif
        pop = (m_q.size() != 0) && (!m_valid || ordy);
        if (pop) begin
            h       = m_q.pop_front();
            m_res   = sum_of(h) % (1 << W);
            m_carry = (sum_of(h) >= (1 << W));
            m_op    = int'(h.op);
            m_valid = 1;
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        if (push && !illegal) begin
            m_q.push_back(c);
        end
        m_err = push && illegal;
    endtask

    task automatic compare_all();
        int   hd_a, hd_b, hd_op;
        hd_a = 0; hd_b = 0; hd_op = 0;
        if (m_q.size() != 0) begin
            hd_a  = int'(m_q[0].a);
            hd_b  = int'(m_q[0].b);
            hd_op = int'(m_q[0].op);
        end
        check_eq("in_ready",   32'(in_ready),   32'(m_q.size() < DEPTH));
        check_eq("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check_eq("out_valid",  32'(out_valid),  32'(m_valid));
        check_eq("out_res",    32'(out_res),    32'(m_res));
        check_eq("out_carry",  32'(out_carry),  32'(m_carry));
        check_eq("out_op",     32'(out_op),     32'(m_op));
        check_eq("err_op",     32'(err_op),     32'(m_err));
        check_eq("alu_a",      32'(alu_a),      32'(hd_a));
        check_eq("alu_b",      32'(alu_b),      32'(hd_b));
        check_eq("alu_op",     32'(alu_op),     32'(hd_op));
    endtask

    task automatic do_cycle(input bit v, input cmd_t c, input bit ordy);
        in_valid  = v;
        in_a      = c.a;
        in_b      = c.b;
        in_op     = c.op;
        out_ready = ordy;
        model_step(v, c, ordy);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic cmd_t mk(input int a, input int b, input int op);
        cmd_t c;
        c.a  = W'(a);
        c.b  = W'(b);
        c.op = 3'(op);
        return c;
    endfunction

    function automatic cmd_t rand_cmd(input int op_max);
        return mk($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1),
                  $urandom_range(0, op_max));
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, mk(0, 0, 0), 1);
    endtask

    // Asserts reset between edges and checks the clear is immediate
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
        check_eq("rst_out_valid",  32'(out_valid),  32'd0);
        check_eq("rst_out_res",    32'(out_res),    32'd0);
        check_eq("rst_out_op",     32'(out_op),     32'd0);
        check_eq("rst_err_op",     32'(err_op),     32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_all();

        // Reset mid-stream with three commands queued
        for (int i = 0; i < 4; i++) do_cycle(1, mk(3 + i, 4, 1), 0);
        check_eq("pre_rst_count", 32'(fifo_count), 32'd3);
        async_reset();

        // Single command latency and arithmetic
        do_cycle(1, mk(4'hE, 4'hB, 0), 1);
        check_eq("single_t_valid", 32'(out_valid), 32'd0);
        do_cycle(0, mk(0, 0, 0), 1);
        check_eq("single_valid", 32'(out_valid), 32'd1);
        check_eq("single_res",   32'(out_res),   32'h9);
        check_eq("single_carry", 32'(out_carry), 32'd1);
        check_eq("single_op",    32'(out_op),    32'd0);
        idle(2);

        // Fill: six offered with the consumer stalled, five fit
        for (int i = 0; i < 6; i++) sc_cmd[i] = rand_cmd(5);
        for (int i = 0; i < 6; i++) do_cycle(1, sc_cmd[i], 0);
        check_eq("full_count",     32'(fifo_count), 32'd4);
        check_eq("full_in_ready",  32'(in_ready),   32'd0);
        check_eq("full_out_valid", 32'(out_valid),  32'd1);
        do_cycle(0, mk(0, 0, 0), 0);
        check_eq("stall_hold_res", 32'(out_res), 32'(sum_of(sc_cmd[0]) % 16));

        // Drain in push order, one per cycle
        check_eq("drain_res0", 32'(out_res), 32'(sum_of(sc_cmd[0]) % 16));
        for (int i = 1; i < 5; i++) begin
            do_cycle(0, mk(0, 0, 0), 1);
            check_eq("drain_valid", 32'(out_valid), 32'd1);
            check_eq("drain_res",   32'(out_res),   32'(sum_of(sc_cmd[i]) % 16));
            check_eq("drain_op",    32'(out_op),    32'(sc_cmd[i].op));
        end
        do_cycle(0, mk(0, 0, 0), 1);
        check_eq("drain_end_valid", 32'(out_valid), 32'd0);
        check_eq("drain_hold_res",  32'(out_res),   32'(sum_of(sc_cmd[4]) % 16));

        // Simultaneous push and pop with two queued
        for (int i = 0; i < 3; i++) do_cycle(1, rand_cmd(5), 0);
        check_eq("simul_pre_count", 32'(fifo_count), 32'd2);
        do_cycle(1, rand_cmd(5), 1);
        check_eq("simul_count", 32'(fifo_count), 32'd2);
        idle(5);

`ifdef ALU_OPCHECK_EN
        do_cycle(1, mk(5, 5, 7), 1);
        check_eq("opchk_err",   32'(err_op),     32'd1);
        check_eq("opchk_count", 32'(fifo_count), 32'd0);
        do_cycle(0, mk(0, 0, 0), 1);
        check_eq("opchk_err_end", 32'(err_op),    32'd0);
        check_eq("opchk_novalid", 32'(out_valid), 32'd0);
`endif

        // Random traffic with one asynchronous reset partway through
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset();
            do_cycle($urandom_range(0, 9) < 7, rand_cmd(7), $urandom_range(0, 9) < 6);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
